camera_capture_ctrl: RTL and testbench

Capture sequencer between the camera decoder's pixel stream (10-bit pixel, write strobe, frame marker) and the frame-buffer write FIFO. It arms on a software start command and aligns to the next frame start. It counts a configured number of frames, packs three 10-bit pixels per 32-bit FIFO word, and flushes partial words at frame end. It reports frame completion, overflow and short/long-frame errors to the register block.

---
 rtl/camera_capture_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_camera_capture_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/camera_capture_ctrl.sv
// ---------------------------------------------------------------------------
// camera_capture_ctrl
//
// Capture sequencer that sits between the camera decoder pixel stream and
// the frame-buffer write FIFO. A software start arms the block. Capture then
// aligns to the next frame_start. Three 10-bit pixels are packed into each
// 32-bit FIFO word:
//   bit31   first word of the frame
//   bit30   last word of the frame (also set on partial flushes)
//   [29:0]  pixel slots 2..0
// A run ends after cfg_frames frames, or continues until abort when
// cfg_frames is 0.
//
// Ports
//   clk_i          clock, rising edge
//   reset_ni       asynchronous reset, active low
//   cmd_start_i    pulse: arm a capture run (only honoured in IDLE)
//   cmd_abort_i    pulse: stop immediately (flushes a partial word if any)
//   cfg_frames_i   frames per run, 0 = continuous
//   frame_start_i  pulse from decoder at start of frame
//   pix_valid_i    pixel strobe
//   pix_data_i     pixel value
//   fifo_full_i    downstream FIFO full
//   fifo_wr_o      FIFO write strobe
//   fifo_data_o    packed word (holds last written word)
//   busy_o         state != IDLE
//   frame_done_o   pulse with the write of a frame's last word
//   frames_done_o  frames completed in this run
//   err_overflow_o sticky: a word was dropped on fifo_full
//   err_short_o    sticky: frame_start before the frame was complete
//   err_long_o     sticky: pixels after a completed frame, before frame_start
// ---------------------------------------------------------------------------
module camera_capture_ctrl #(
    parameter int PIX_PER_FRAME = 463360,
    parameter int CNT_W         = 20,
    parameter int FRM_W         = 8
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             cmd_start_i,
    input  logic             cmd_abort_i,
    input  logic [FRM_W-1:0] cfg_frames_i,
    input  logic             frame_start_i,
    input  logic             pix_valid_i,
    input  logic [9:0]       pix_data_i,
    input  logic             fifo_full_i,
    output logic             fifo_wr_o,
    output logic [31:0]      fifo_data_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic [FRM_W-1:0] frames_done_o,
    output logic             err_overflow_o,
    output logic             err_short_o,
    output logic             err_long_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_CAP   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIX_PER_FRAME - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       slot_q, slot_d;
    logic [29:0]      pack_q, pack_d;
    logic             first_q, first_d;
    // Set once a frame completes; arms long-frame detection in ARMED.
    logic             done_seen_q, done_seen_d;
    logic             wr_q, wr_d;
    logic [31:0]      data_q, data_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [FRM_W-1:0] frames_q, frames_d;
    logic             ovf_q, ovf_d;
    logic             short_q, short_d;
    logic             long_q, long_d;

    // Working values: frame base (possibly restarted by frame_start this
    // cycle) that the incoming pixel is applied on top of.
    logic [CNT_W-1:0] cnt_b;
    logic [1:0]       slot_b;
    logic [29:0]      pack_b;
    logic             first_b;
    logic             take;
    logic [29:0]      pack_n;
    logic             is_last;
    logic             issue;
    logic [31:0]      word_v;

    always_comb begin
        state_d     = state_q;
        frames_d    = frames_q;
        ovf_d       = ovf_q;
        short_d     = short_q;
        long_d      = long_q;
        done_seen_d = done_seen_q;
        data_d      = data_q;
        wr_d        = 1'b0;
        done_d      = 1'b0;
        cnt_b       = cnt_q;
        slot_b      = slot_q;
        pack_b      = pack_q;
        first_b     = first_q;
        take        = 1'b0;
        pack_n      = '0;
        is_last     = 1'b0;
        issue       = 1'b0;
        word_v      = '0;

        case (state_q)
            S_IDLE: begin
                if (cmd_start_i) begin
                    state_d     = S_ARMED;
                    frames_d    = '0;
                    ovf_d       = 1'b0;
                    short_d     = 1'b0;
                    long_d      = 1'b0;
                    done_seen_d = 1'b0;
                end
            end
            S_ARMED: begin
                if (cmd_abort_i) begin
                    state_d = S_IDLE;
                end else if (frame_start_i) begin
                    state_d     = S_CAP;
                    done_seen_d = 1'b0;
                    cnt_b       = '0;
                    slot_b      = '0;
                    pack_b      = '0;
                    first_b     = 1'b1;
                    take        = pix_valid_i;
                end else if (pix_valid_i && done_seen_q) begin
                    long_d = 1'b1;
                end
            end
            S_CAP: begin
                if (cmd_abort_i) begin
                    state_d = (slot_q != 2'd0) ? S_FLUSH : S_IDLE;
                end else begin
                    if (frame_start_i) begin
                        // Short frame: flush what is packed, restart the frame.
                        short_d = 1'b1;
                        if (slot_q != 2'd0) begin
                            issue  = 1'b1;
                            word_v = {first_q, 1'b1, pack_q};
                        end
                        cnt_b   = '0;
                        slot_b  = '0;
                        pack_b  = '0;
                        first_b = 1'b1;
                    end
                    take = pix_valid_i;
                end
            end
            default: begin // S_FLUSH
                issue   = 1'b1;
                word_v  = {first_q, 1'b1, pack_q};
                state_d = S_IDLE;
                slot_b  = '0;
                pack_b  = '0;
            end
        endcase

        cnt_d   = cnt_b;
        slot_d  = slot_b;
        pack_d  = pack_b;
        first_d = first_b;

        if (take) begin
            pack_n = pack_b;
            case (slot_b)
                2'd0:    pack_n[9:0]   = pix_data_i;
                2'd1:    pack_n[19:10] = pix_data_i;
                default: pack_n[29:20] = pix_data_i;
            endcase
            is_last = (cnt_b == LAST_CNT);
            cnt_d   = (cnt_b == '1) ? cnt_b : cnt_b + 1'b1;
            if (slot_b == 2'd2 || is_last) begin
                issue   = 1'b1;
                word_v  = {first_b, is_last, pack_n};
                first_d = 1'b0;
                slot_d  = '0;
                pack_d  = '0;
            end else begin
                slot_d = slot_b + 2'd1;
                pack_d = pack_n;
            end
            if (is_last) begin
                done_d      = 1'b1;
                done_seen_d = 1'b1;
                frames_d    = (frames_q == '1) ? frames_q : frames_q + 1'b1;
                if (cfg_frames_i != '0 &&
                    ({1'b0, frames_q} + 1'b1) == {1'b0, cfg_frames_i})
                    state_d = S_IDLE;
                else
                    state_d = S_ARMED;
            end
        end

        // Dropped words still advance counting; only the write is lost.
        if (issue) begin
            if (fifo_full_i) begin
                ovf_d = 1'b1;
            end else begin
                wr_d   = 1'b1;
                data_d = word_v;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            slot_q      <= '0;
            pack_q      <= '0;
            first_q     <= 1'b0;
            done_seen_q <= 1'b0;
            wr_q        <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            frames_q    <= '0;
            ovf_q       <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            pack_q      <= pack_d;
            first_q     <= first_d;
            done_seen_q <= done_seen_d;
            wr_q        <= wr_d;
            data_q      <= data_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            frames_q    <= frames_d;
            ovf_q       <= ovf_d;
            short_q     <= short_d;
            long_q      <= long_d;
        end
    end

    assign fifo_wr_o      = wr_q;
    assign fifo_data_o    = data_q;
    assign busy_o         = busy_q;
    assign frame_done_o   = done_q;
    assign frames_done_o  = frames_q;
    assign err_overflow_o = ovf_q;
    assign err_short_o    = short_q;
    assign err_long_o     = long_q;

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Directed table-driven bench for camera_capture_ctrl with a 7-pixel frame.
// Inputs change on the falling edge; outputs are checked on the next falling
// edge, i.e. after the rising edge that consumed the row's inputs.
module tb_camera_capture_ctrl;
    localparam int PPF = 7;

    localparam logic [31:0] W1 = 32'h8030_0801; // first word, pixels 1,2,3
    localparam logic [31:0] W2 = 32'h0060_1404; // pixels 4,5,6
    localparam logic [31:0] W3 = 32'h4000_0007; // last word, pixel 7 only

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_start, cmd_abort, frame_start, pix_valid, fifo_full;
    logic [7:0]  cfg_frames;
    logic [9:0]  pix_data;
    logic        fifo_wr, busy, frame_done, err_ovf, err_short, err_long;
    logic [31:0] fifo_data;
    logic [7:0]  frames_done;

    always #5 clk = ~clk;

    camera_capture_ctrl #(.PIX_PER_FRAME(PPF), .CNT_W(20), .FRM_W(8)) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .cmd_start_i(cmd_start), .cmd_abort_i(cmd_abort),
        .cfg_frames_i(cfg_frames), .frame_start_i(frame_start),
        .pix_valid_i(pix_valid), .pix_data_i(pix_data),
        .fifo_full_i(fifo_full), .fifo_wr_o(fifo_wr), .fifo_data_o(fifo_data),
        .busy_o(busy), .frame_done_o(frame_done), .frames_done_o(frames_done),
        .err_overflow_o(err_ovf), .err_short_o(err_short), .err_long_o(err_long)
    );

    typedef struct {
        logic        cs, ab, fs, pv;
        logic [9:0]  pd;
        logic        full;
        logic        wr;
        logic [31:0] data;
        logic        done, bsy;
        logic [7:0]  fr;
        logic [2:0]  err; // {overflow, short, long}
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic cs, ab, fs, pv, input logic [9:0] pd, input logic full,
                       input logic wr, input logic [31:0] data, input logic done, bsy,
                       input logic [7:0] fr, input logic [2:0] err);
        vec_t v;
        v = '{cs, ab, fs, pv, pd, full, wr, data, done, bsy, fr, err};
        tbl.push_back(v);
    endtask

    // Seven pixels 1..7 of a fully received frame (frame_start already given).
    task automatic add_frame(input logic [7:0] fr_prev, input logic busy_end, input logic [2:0] err);
        for (int p = 1; p <= 7; p++) begin
            add(0, 0, 0, 1, 10'(p), 0,
                (p == 3 || p == 6 || p == 7),
                (p == 3) ? W1 : (p == 6) ? W2 : W3,
                (p == 7), (p == 7) ? busy_end : 1'b1,
                (p == 7) ? fr_prev + 8'd1 : fr_prev, err);
        end
    endtask

    task automatic drive(input logic cs, ab, fs, pv, input logic [9:0] pd, input logic full);
        cmd_start = cs; cmd_abort = ab; frame_start = fs;
        pix_valid = pv; pix_data = pd; fifo_full = full;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].cs, tbl[i].ab, tbl[i].fs, tbl[i].pv, tbl[i].pd, tbl[i].full);
            @(negedge clk);
            chk($sformatf("%s[%0d].fifo_wr", tag, i), 32'(fifo_wr), 32'(tbl[i].wr));
            chk($sformatf("%s[%0d].frame_done", tag, i), 32'(frame_done), 32'(tbl[i].done));
            chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("%s[%0d].frames_done", tag, i), 32'(frames_done), 32'(tbl[i].fr));
            chk($sformatf("%s[%0d].err", tag, i), 32'({err_ovf, err_short, err_long}), 32'(tbl[i].err));
            if (tbl[i].wr)
                chk($sformatf("%s[%0d].fifo_data", tag, i), fifo_data, tbl[i].data);
        end
        tbl.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        cfg_frames = 8'd2;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
        chk("reset.outputs", {fifo_wr, frame_done, busy, err_ovf, err_short, err_long}, 32'd0);
        chk("reset.frames_done", 32'(frames_done), 32'd0);
        chk("reset.fifo_data", fifo_data, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Nominal run of two frames, then pixels in IDLE are ignored.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000);
        add_frame(0, 1, 3'b000);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3'b000);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 3'b000);
        add_frame(1, 0, 3'b000);
        add(0, 0, 0, 1, 10'h077, 0, 0, 0, 0, 0, 2, 3'b000);

        // Alignment, short frame, long frame, overflow.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000);
        add(0, 0, 0, 1, 10'h100, 0, 0, 0, 0, 1, 0, 3'b000);
        add(0, 0, 0, 1, 10'h101, 0, 0, 0, 0, 1, 0, 3'b000);
        add(0, 0, 1, 1, 10'h3FF, 0, 0, 0, 0, 1, 0, 3'b000);
        add(0, 0, 0, 1, 10'h002, 0, 0, 0, 0, 1, 0, 3'b000);
        add(0, 0, 0, 1, 10'h003, 0, 1, 32'h8030_0BFF, 0, 1, 0, 3'b000);
        add(0, 0, 0, 1, 10'h004, 0, 0, 0, 0, 1, 0, 3'b000);
        add(0, 0, 1, 0, 0, 0, 1, 32'h4000_0004, 0, 1, 0, 3'b010);
        add_frame(0, 1, 3'b010);
        add(0, 0, 0, 1, 10'h055, 0, 0, 0, 0, 1, 1, 3'b011);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 3'b011);
        add(0, 0, 0, 1, 10'd1, 0, 0, 0, 0, 1, 1, 3'b011);
        add(0, 0, 0, 1, 10'd2, 0, 0, 0, 0, 1, 1, 3'b011);
        add(0, 0, 0, 1, 10'd3, 0, 1, W1, 0, 1, 1, 3'b011);
        add(0, 0, 0, 1, 10'd4, 1, 0, 0, 0, 1, 1, 3'b011);
        add(0, 0, 0, 1, 10'd5, 1, 0, 0, 0, 1, 1, 3'b011);
        add(0, 0, 0, 1, 10'd6, 1, 0, 0, 0, 1, 1, 3'b111);
        add(0, 0, 0, 1, 10'd7, 0, 1, W3, 1, 0, 2, 3'b111);

        // Abort with two packed pixels: one flush word, then IDLE.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000);
        for (int p = 1; p <= 5; p++)
            add(0, 0, 0, 1, 10'(p), 0, (p == 3), W1, 0, 1, 0, 3'b000);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000);
        add(0, 0, 0, 0, 0, 0, 1, 32'h4000_1404, 0, 0, 0, 3'b000);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);

        // Abort on a word boundary: no flush; abort in ARMED.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000);
        for (int p = 1; p <= 6; p++)
            add(0, 0, 0, 1, 10'(p), 0, (p == 3 || p == 6), (p == 3) ? W1 : W2, 0, 1, 0, 3'b000);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        run_table("tbl");

        // Asynchronous reset in the middle of a frame.
        drive(1, 0, 0, 0, 0, 0); @(negedge clk);
        drive(0, 0, 1, 0, 0, 0); @(negedge clk);
        drive(0, 0, 0, 1, 10'd1, 0); @(negedge clk);
        drive(0, 0, 0, 1, 10'd2, 0); @(negedge clk);
        chk("pre_reset.busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset.outputs", {fifo_wr, frame_done, busy, err_ovf, err_short, err_long}, 32'd0);
        chk("async_reset.fifo_data", fifo_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int p = 1; p <= 3; p++)
            add(0, 0, (p == 1), 1, 10'(p), 0, 0, 0, 0, 0, 0, 3'b000);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000);
        add_frame(0, 1, 3'b000);
        run_table("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
